lbm_stream_engine: RTL

- Streaming stage of the D2Q9 lattice-Boltzmann pipeline. Runs after the collision phase has filled fout memory and before the next moment/equilibrium sweep reads fin memory.
- Sweeps every cell and pushes each post-collision population to its neighbour's fin slot.
- Applies half-way bounce-back at the lid, bottom, left and right walls.
- Driven by a start/done handshake from the main controller.

---
 rtl/lbm_pkg.sv | 15 +
 rtl/lbm_neighbor_addr.sv | 52 +++++
 rtl/lbm_stream_engine.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lbm_pkg.sv
// D2Q9 lattice constants shared by the streaming engine and its neighbour
// address unit. The optional LBM_PERIODIC_X_EN build is handled in
// lbm_neighbor_addr; nothing here depends on it.
package lbm_pkg;

    localparam int Q = 9;

    typedef logic [3:0] dir_t;

    // Lattice velocity components and opposite direction for dirs 0..8
    localparam int   CX  [Q] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
    localparam int   CY  [Q] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
    localparam dir_t OPP [Q] = '{4'd0, 4'd3, 4'd4, 4'd1, 4'd2, 4'd7, 4'd8, 4'd5, 4'd6};

endpackage

// File: rtl/lbm_neighbor_addr.sv
// Combinational destination lookup for one streamed population.
// In range: neighbour cell, same direction. Off the grid: half-way
// bounce-back into the source cell on the opposite direction.
// Build option LBM_PERIODIC_X_EN wraps x instead of bouncing on the
// left/right walls (lid and bottom always bounce).
module lbm_neighbor_addr
    import lbm_pkg::*;
#(
    parameter int NX            = 16,
    parameter int NY            = 16,
    parameter int ADDRESS_WIDTH = $clog2(NX*NY),
    parameter int XW            = $clog2(NX),
    parameter int YW            = $clog2(NY)
) (
    input  logic [XW-1:0]            x,
    input  logic [YW-1:0]            y,
    input  dir_t                     dir,
    output logic [ADDRESS_WIDTH-1:0] dest_addr,
    output dir_t                     dest_dir,
    output logic                     bounced
);

    int   d;
    int   xd;
    int   yd;
    logic x_in;
    logic y_in;

    // Target coordinates, wall test and final (addr, dir) selection
    always_comb begin
        d    = (dir > 4'd8) ? 0 : int'(dir);
        xd   = int'(x) + CX[d];
        yd   = int'(y) + CY[d];
        x_in = (xd >= 0) && (xd < NX);
        y_in = (yd >= 0) && (yd < NY);
`ifdef LBM_PERIODIC_X_EN
        if (y_in && !x_in) begin
            xd   = (xd < 0) ? xd + NX : xd - NX;
            x_in = 1'b1;
        end
`endif
        bounced = !(x_in && y_in);
        if (bounced) begin
            dest_addr = ADDRESS_WIDTH'(int'(y) * NX + int'(x));
            dest_dir  = OPP[d];
        end else begin
            dest_addr = ADDRESS_WIDTH'(yd * NX + xd);
            dest_dir  = dir;
        end
    end

endmodule

// File: rtl/lbm_stream_engine.sv
// D2Q9 streaming stage: for each cell, read all 9 post-collision
// populations from fout, then write each one to its destination fin
// bank/address (neighbour, or bounced back at walls). 11 cycles/cell:
// READ, WAIT, 9x WRITE. Build option LBM_PERIODIC_X_EN (see
// lbm_neighbor_addr) turns the left/right walls into a periodic seam.
module lbm_stream_engine
    import lbm_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NX            = 16,
    parameter int NY            = 16,
    parameter int GRID_DIM      = NX*NY,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     fout_rd_en,
    output logic [ADDRESS_WIDTH-1:0] fout_addr,
    input  logic [Q*DATA_WIDTH-1:0]  fout_rdata,
    output logic                     WE_fin_mem,
    output logic [ADDRESS_WIDTH-1:0] fin_addr,
    output logic [3:0]               fin_dir,
    output logic [DATA_WIDTH-1:0]    fin_wdata
);

    localparam int XW = $clog2(NX);
    localparam int YW = $clog2(NY);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t                        state_q;
    logic [ADDRESS_WIDTH-1:0]      cell_q;
    dir_t                          dir_q;
    dir_t                          dir_d;
    logic [Q-1:0][DATA_WIDTH-1:0]  buf_q;
    logic [XW-1:0]                 cell_x;
    logic [YW-1:0]                 cell_y;
    logic [ADDRESS_WIDTH-1:0]      nb_addr;
    dir_t                          nb_dir;
    logic                          nb_bounced;
    logic [DATA_WIDTH-1:0]         wdata_d;

    assign cell_x = XW'(int'(cell_q) % NX);
    assign cell_y = YW'(int'(cell_q) / NX);

    // Outputs are registered, so the destination is looked up for the
    // direction that will be presented in the *next* cycle.
    assign dir_d   = (state_q == S_WRITE && dir_q != 4'd8) ? dir_q + 4'd1 : 4'd0;
    assign wdata_d = (state_q == S_WAIT) ? fout_rdata[DATA_WIDTH-1:0] : buf_q[dir_d];

    lbm_neighbor_addr #(
        .NX            (NX),
        .NY            (NY),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .XW            (XW),
        .YW            (YW)
    ) u_nb (
        .x         (cell_x),
        .y         (cell_y),
        .dir       (dir_d),
        .dest_addr (nb_addr),
        .dest_dir  (nb_dir),
        .bounced   (nb_bounced)
    );

    // Sweep FSM with registered handshake and memory strobes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            cell_q     <= '0;
            dir_q      <= '0;
            buf_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fout_rd_en <= 1'b0;
            fout_addr  <= '0;
            WE_fin_mem <= 1'b0;
            fin_addr   <= '0;
            fin_dir    <= '0;
            fin_wdata  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_READ;
                        cell_q     <= '0;
                        busy       <= 1'b1;
                        fout_rd_en <= 1'b1;
                        fout_addr  <= '0;
                    end
                end
                S_READ: begin
                    state_q    <= S_WAIT;
                    fout_rd_en <= 1'b0;
                end
                S_WAIT: begin
                    buf_q      <= fout_rdata;
                    state_q    <= S_WRITE;
                    dir_q      <= '0;
                    WE_fin_mem <= 1'b1;
                    // A wall hit always lands back in the source cell
                    fin_addr   <= nb_bounced ? cell_q : nb_addr;
                    fin_dir    <= nb_dir;
                    fin_wdata  <= wdata_d;
                end
                S_WRITE: begin
                    if (dir_q == 4'd8) begin
                        WE_fin_mem <= 1'b0;
                        if (cell_q == ADDRESS_WIDTH'(GRID_DIM-1)) begin
                            state_q <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_q    <= S_READ;
                            cell_q     <= cell_q + 1'b1;
                            fout_rd_en <= 1'b1;
                            fout_addr  <= cell_q + 1'b1;
                        end
                    end else begin
                        dir_q     <= dir_d;
                        fin_addr  <= nb_bounced ? cell_q : nb_addr;
                        fin_dir   <= nb_dir;
                        fin_wdata <= wdata_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
